// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the multi-port register file
// Contents: default XLEN/NREG, derived address width, write-port indices.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  // Write-port indices; the higher index has priority on address collisions.
  localparam int WP_ALU = 0;
  localparam int WP_LSU = 1;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - bus interface between issue/writeback logic and regfile_mp
// master: drives write ports, issue marker and read addresses; samples read data,
//         busy flags and the pending vector.
// slave : the register file side.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [1:0]                i_wr_en;
  logic [1:0][AW-1:0]        i_wr_addr;
  logic [1:0][XLEN-1:0]      i_wr_data;
  logic                      i_iss_vld;
  logic [AW-1:0]             i_iss_addr;
  logic [NRD-1:0][AW-1:0]    i_rs_addr;
  logic [NRD-1:0][XLEN-1:0]  o_rs_data;
  logic [NRD-1:0]            o_rs_busy;
  logic [NREG-1:0]           o_pend;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_iss_vld, i_iss_addr, i_rs_addr,
    input  o_rs_data, o_rs_busy, o_pend
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_iss_vld, i_iss_addr, i_rs_addr,
    output o_rs_data, o_rs_busy, o_pend
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - pending-write scoreboard for regfile_mp
// Ports: i_clk, i_rst (async active-low), i_wr_en/i_wr_addr (clear sources),
//        i_iss_vld/i_iss_addr (set source), o_pend (one bit per register).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_wr_en,
  input  logic [1:0][AW-1:0] i_wr_addr,
  input  logic               i_iss_vld,
  input  logic [AW-1:0]      i_iss_addr,
  output logic [NREG-1:0]    o_pend
);

  logic [NREG-1:0] r_pend;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pend <= '0;
    end else begin
      for (int a = 1; a < NREG; a++) begin
        // A new issue supersedes the producer whose writeback lands this cycle.
        if (i_iss_vld && i_iss_addr == AW'(a))
          r_pend[a] <= 1'b1;
        else if ((i_wr_en[WP_ALU] && i_wr_addr[WP_ALU] == AW'(a)) ||
                 (i_wr_en[WP_LSU] && i_wr_addr[WP_LSU] == AW'(a)))
          r_pend[a] <= 1'b0;
      end
      r_pend[0] <= 1'b0;
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass and RAW scoreboard
// Ports: i_clk, i_rst (async active-low), bus (regfile_mp_if.slave): two
//        prioritised write ports, issue marker, NRD combinational read ports
//        with busy flags, raw pending vector.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  regfile_mp_if.slave bus
);

  localparam int AW = $clog2(NREG);

  // x0 is never stored.
  logic [XLEN-1:0] r_regs [1:NREG-1];
  logic [NREG-1:0] w_pend;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int a = 1; a < NREG; a++) r_regs[a] <= '0;
    end else begin
      for (int a = 1; a < NREG; a++) begin
        if (bus.i_wr_en[WP_LSU] && bus.i_wr_addr[WP_LSU] == AW'(a))
          r_regs[a] <= bus.i_wr_data[WP_LSU];
        else if (bus.i_wr_en[WP_ALU] && bus.i_wr_addr[WP_ALU] == AW'(a))
          r_regs[a] <= bus.i_wr_data[WP_ALU];
      end
    end
  end

  regfile_sb #(.NREG(NREG), .AW(AW)) u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (bus.i_wr_en),
    .i_wr_addr  (bus.i_wr_addr),
    .i_iss_vld  (bus.i_iss_vld),
    .i_iss_addr (bus.i_iss_addr),
    .o_pend     (w_pend)
  );

  assign bus.o_pend = w_pend;

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_arr;
    logic [XLEN-1:0] w_data;
    logic            w_hit0;
    logic            w_hit1;

    assign w_addr = bus.i_rs_addr[r];

    always_comb begin
      w_arr = '0;
      for (int a = 1; a < NREG; a++)
        if (w_addr == AW'(a)) w_arr = r_regs[a];
    end

    assign w_hit0 = (BYPASS != 0) && bus.i_wr_en[WP_ALU] && (bus.i_wr_addr[WP_ALU] == w_addr);
    assign w_hit1 = (BYPASS != 0) && bus.i_wr_en[WP_LSU] && (bus.i_wr_addr[WP_LSU] == w_addr);

    // Reset gating keeps bypassed write data from leaking out while in reset.
    always_comb begin
      w_data = w_arr;
      if (w_hit1)      w_data = bus.i_wr_data[WP_LSU];
      else if (w_hit0) w_data = bus.i_wr_data[WP_ALU];
      if (w_addr == '0 || !i_rst) w_data = '0;
    end

    assign bus.o_rs_data[r] = w_data;
    // A same-cycle forwarded writeback satisfies the read, so no stall.
    assign bus.o_rs_busy[r] = i_rst && w_pend[w_addr] && !(w_hit0 || w_hit1);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (bypass and non-bypass builds)
module tb_regfile_mp;

  logic clk;
  logic rst_n;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             iss_vld;
  logic [4:0]       iss_addr;
  logic [1:0][4:0]  rs_addr;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;

  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) ifb ();
  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) ifn ();

  assign ifb.i_wr_en = wr_en;   assign ifn.i_wr_en = wr_en;
  assign ifb.i_wr_addr = wr_addr; assign ifn.i_wr_addr = wr_addr;
  assign ifb.i_wr_data = wr_data; assign ifn.i_wr_data = wr_data;
  assign ifb.i_iss_vld = iss_vld; assign ifn.i_iss_vld = iss_vld;
  assign ifb.i_iss_addr = iss_addr; assign ifn.i_iss_addr = iss_addr;
  assign ifb.i_rs_addr = rs_addr; assign ifn.i_rs_addr = rs_addr;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) u_byp (
    .i_clk(clk), .i_rst(rst_n), .bus(ifb));
  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) u_nob (
    .i_clk(clk), .i_rst(rst_n), .bus(ifn));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr_model();
    for (int a = 0; a < 32; a++) m_regs[a] = '0;
    m_pend = '0;
  endtask

  function automatic logic [31:0] exp_data(input bit byp, input logic [4:0] a);
    if (!rst_n || a == 0) return '0;
    if (byp && wr_en[1] && wr_addr[1] == a) return wr_data[1];
    if (byp && wr_en[0] && wr_addr[0] == a) return wr_data[0];
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] a);
    logic hit;
    hit = (wr_en[1] && wr_addr[1] == a) || (wr_en[0] && wr_addr[0] == a);
    if (!rst_n) return 1'b0;
    return m_pend[a] && !(byp && hit);
  endfunction

  // Reference state advances on the edge; writes apply in port order so port 1
  // lands last, and issue is applied after the clears so it wins.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wr_addr[p] != 0) begin
          m_regs[wr_addr[p]] = wr_data[p];
          m_pend[wr_addr[p]] = 1'b0;
        end
      if (iss_vld && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    end else begin
      clr_model();
    end
  end

  always @(negedge clk) begin
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("byp_data[%0d]", r), ifb.o_rs_data[r], exp_data(1'b1, rs_addr[r]));
      chk($sformatf("nob_data[%0d]", r), ifn.o_rs_data[r], exp_data(1'b0, rs_addr[r]));
      chk($sformatf("byp_busy[%0d]", r), 32'(ifb.o_rs_busy[r]), 32'(exp_busy(1'b1, rs_addr[r])));
      chk($sformatf("nob_busy[%0d]", r), 32'(ifn.o_rs_busy[r]), 32'(exp_busy(1'b0, rs_addr[r])));
    end
    chk("byp_pend", ifb.o_pend, rst_n ? m_pend : 32'h0);
    chk("nob_pend", ifn.o_pend, rst_n ? m_pend : 32'h0);
  end

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; iss_vld = 1'b0; iss_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    clr_model();
    rs_addr = '{5'd5, 5'd5};
    wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'h11111111;
    #3;
    chk("rst_rd_x5_byp", ifb.o_rs_data[0], 32'h0);
    chk("rst_pend", ifb.o_pend, 32'h0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; idle(); rs_addr = '{5'd5, 5'd5};
    #1; chk("post_rst_x5", ifb.o_rs_data[0], 32'h0);

    step(); wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'h12345678;
    step(); rs_addr = '{5'd7, 5'd7};
    #1; chk("x7_p0", ifb.o_rs_data[0], 32'h12345678);
        chk("x7_p1", ifb.o_rs_data[1], 32'h12345678);
        chk("x7_nob", ifn.o_rs_data[1], 32'h12345678);

    step(); wr_en = 2'b11; wr_addr = '{5'd0, 5'd0}; wr_data = '{32'hDEADBEEF, 32'hDEADBEEF};
    rs_addr = '{5'd0, 5'd0};
    #1; chk("x0_wr_cycle", ifb.o_rs_data[0], 32'h0);
    step(); rs_addr = '{5'd0, 5'd0};
    #1; chk("x0_after", ifb.o_rs_data[0], 32'h0);

    step(); wr_en = 2'b11; wr_addr = '{5'd3, 5'd3}; wr_data = '{32'h5555FFFF, 32'hAAAA0000};
    step(); rs_addr = '{5'd3, 5'd3};
    #1; chk("dual_x3", ifb.o_rs_data[0], 32'h5555FFFF);

    step(); wr_en = 2'b11; wr_addr = '{5'd9, 5'd4}; wr_data = '{32'h99999999, 32'h44444444};
    step(); rs_addr = '{5'd9, 5'd4};
    #1; chk("dual_x4", ifb.o_rs_data[0], 32'h44444444);
        chk("dual_x9", ifb.o_rs_data[1], 32'h99999999);

    step(); wr_en[0] = 1'b1; wr_addr[0] = 5'd10; wr_data[0] = 32'hCAFEF00D; rs_addr = '{5'd10, 5'd10};
    #1; chk("byp_x10_same", ifb.o_rs_data[0], 32'hCAFEF00D);
        chk("nob_x10_same", ifn.o_rs_data[0], 32'h0);
    step(); rs_addr = '{5'd10, 5'd10};
    #1; chk("nob_x10_next", ifn.o_rs_data[0], 32'hCAFEF00D);

    step(); iss_vld = 1'b1; iss_addr = 5'd12; rs_addr = '{5'd12, 5'd12};
    step(); rs_addr = '{5'd12, 5'd12};
    #1; chk("pend12_set", 32'(ifb.o_pend[12]), 32'h1);
        chk("busy12", 32'(ifb.o_rs_busy[0]), 32'h1);
    step(); wr_en[1] = 1'b1; wr_addr[1] = 5'd12; wr_data[1] = 32'h12121212;
    #1; chk("busy12_byp_wr", 32'(ifb.o_rs_busy[0]), 32'h0);
        chk("busy12_nob_wr", 32'(ifn.o_rs_busy[0]), 32'h1);
        chk("x12_byp_data", ifb.o_rs_data[1], 32'h12121212);
    step();
    #1; chk("pend12_clr", 32'(ifb.o_pend[12]), 32'h0);

    step(); iss_vld = 1'b1; iss_addr = 5'd0;
    step();
    #1; chk("pend_x0", ifb.o_pend, 32'h0);

    step(); iss_vld = 1'b1; iss_addr = 5'd15;
    wr_en[0] = 1'b1; wr_addr[0] = 5'd15; wr_data[0] = 32'h15151515;
    step(); rs_addr = '{5'd7, 5'd15};
    #1; chk("pend15_kept", 32'(ifb.o_pend[15]), 32'h1);
        chk("x15_written", ifn.o_rs_data[0], 32'h15151515);

    #1; rst_n = 1'b0; clr_model();
    #1; chk("async_pend", ifb.o_pend, 32'h0);
        chk("async_x15", ifb.o_rs_data[0], 32'h0);
        chk("async_x7", ifn.o_rs_data[1], 32'h0);
    step(); step(); rst_n = 1'b1;

    repeat (3000) begin
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      if (!rst_n) clr_model();
      for (int p = 0; p < 2; p++) begin
        wr_en[p]   = ($urandom_range(0, 1) == 1);
        wr_addr[p] = rnd_addr();
        wr_data[p] = $urandom;
      end
      iss_vld  = ($urandom_range(0, 2) == 0);
      iss_addr = rnd_addr();
      for (int r = 0; r < 2; r++) rs_addr[r] = rnd_addr();
    end
    step(); rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
